bram_bist_ctrl: RTL and testbench
=================================

Name: bram_bist_ctrl

Overview:
March-style built-in self-test initiator that drives one port of a true-dual-port block RAM. It connects to the rce/ra/rq/wce/wa/wd signals of that port, and the RAM port is clocked by the same clk.
- Sweeps the array with four phases: write pattern, read/compare, write inverted pattern, read/compare.
- Reports pass/fail, a saturating error count and the first failing address.
- Sits between test/configuration logic and every BRAM instance in the fabric test suite.

Parameters:
AWIDTH, 10, RAM address width; array depth is 2**AWIDTH
DWIDTH, 36, RAM data width
ECW, 16, error counter width

Ports:
clk  input  1  clock; also clocks the attached RAM port
rst  input  1  asynchronous reset, active-high
start  input  1  start a test run; level-sampled, acted on only in IDLE or DONE
busy  output  1  high while a run is in progress
done  output  1  high in DONE until the next accepted start
pass  output  1  done && (err_cnt == 0)
err_cnt  output  ECW  mismatch count, saturates at all-ones
fail_addr  output  AWIDTH  address of first mismatch in the run; 0 if none
rce  output  1  RAM read enable
ra  output  AWIDTH  RAM read address
rq  input  DWIDTH  RAM read data, valid one cycle after rce
wce  output  1  RAM write enable
wa  output  AWIDTH  RAM write address
wd  output  DWIDTH  RAM write data

Behaviour:
- Reset (async, immediate):
  - FSM=IDLE.
  - busy=done=pass=0, err_cnt=0, fail_addr=0.
  - rce=wce=0, ra=wa=wd=0.
  - Any pending compare is discarded.
- Pattern: P(a) bit i = a[i mod AWIDTH]. Phase 0 uses P(a); phase 1 uses ~P(a).
- States: IDLE, WR0, RD0, DRN0, WR1, RD1, DRN1, DONE.
- start=1 in IDLE or DONE:
  - next state WR0, addr=0.
  - err_cnt, fail_addr and the first-fail flag are cleared.
  - busy=1, done=0.
- start in any other state is ignored.
- WRx: each cycle wce=1, wa=addr, wd=P(addr) (phase-inverted), addr+1. On addr = all-ones, go to RDx with addr wrapped to 0.
- RDx: each cycle rce=1, ra=addr, addr+1.
  - Expected data and a compare-valid flag are registered alongside the read.
  - After addr = all-ones, go to DRNx.
- DRNx: one cycle, no RAM access; the final read's response is compared here. DRN0 -> WR1, DRN1 -> DONE.
- Compare: in the cycle after each read, rq is checked against the delayed expected value.
  - On mismatch, err_cnt+1 (saturating).
  - On the first mismatch of the run, fail_addr is latched from the delayed address.
- rce and wce are never high in the same cycle. Outputs rce, wce, ra, wa and wd are registered.
- Timing, with N=2**AWIDTH and the start sample at edge 0:
  - WR0 occupies cycles 1..N.
  - RD0 occupies cycles N+1..2N.
  - DRN0 is cycle 2N+1.
  - WR1 occupies cycles 2N+2..3N+1.
  - RD1 occupies cycles 3N+2..4N+1.
  - DRN1 is cycle 4N+2.
  - done=1 from cycle 4N+3.
- DONE holds done, pass, err_cnt and fail_addr stable, with busy=0.
- Reset mid-run aborts immediately. Partially written RAM contents are not restored.

Optional Feature:
BRAM_BIST_ERR_INJECT_EN
- Defined: adds ports inj_en (input, 1) and inj_addr (input, AWIDTH).
  - During WR0, if inj_en=1 and addr==inj_addr, wd bit 0 is inverted.
  - This produces exactly one mismatch, in RD0 at inj_addr. WR1 overwrites the corrupted word, so RD1 sees no error from it.
- Undefined: the ports are absent and wd is always the nominal pattern.

Test Plan:
- AWIDTH=4, DWIDTH=8, fault-free 1-cycle-latency RAM model, start pulse at cycle 0 -> busy cycles 1..66, done=1 and pass=1 at cycle 67, err_cnt=0, fail_addr=0.
- Same config, RAM model with bit 3 stuck-at-0 at address 5 -> phase-0 write of 0x55 reads back clean; phase-1 write of 0xAA reads 0xA2. Result: err_cnt=1, fail_addr=5, pass=0.
- start held high throughout a run -> no restart while busy; run ends at cycle 67. Because start is still high in DONE, a new run then begins and err_cnt is cleared.
- rst asserted at cycle 20 (inside RD0) for 2 cycles -> rce, wce, busy and err_cnt drop to 0 asynchronously. A new start then completes with pass=1 after 67 cycles.
- With BRAM_BIST_ERR_INJECT_EN defined, inj_en=1, inj_addr=9 -> err_cnt=1, fail_addr=9, pass=0. With inj_en=0 -> pass=1.
- Saturation: ECW=2, RAM model returning all zeros -> err_cnt stops at 3, fail_addr=1 (first mismatch; addr 0 matches in phase 0), pass=0.

Source files
------------

// File: rtl/bram_bist_ctrl.sv
// ============================================================================
// Module   : bram_bist_ctrl
// Brief    : March-style BIST initiator for one port of a block RAM.
//            It runs four sweeps: write P, read/compare, write ~P, read/compare.
//            Optional macro BRAM_BIST_ERR_INJECT_EN adds single-word fault
//            injection during the first write sweep.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_bist_ctrl #(
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 36,
    parameter int ECW    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ECW-1:0]    err_cnt,
    output logic [AWIDTH-1:0] fail_addr,
    output logic              rce,
    output logic [AWIDTH-1:0] ra,
    input  logic [DWIDTH-1:0] rq,
    output logic              wce,
    output logic [AWIDTH-1:0] wa,
    output logic [DWIDTH-1:0] wd
`ifdef BRAM_BIST_ERR_INJECT_EN
    ,
    input  logic              inj_en,
    input  logic [AWIDTH-1:0] inj_addr
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR0  = 3'd1,
        S_RD0  = 3'd2,
        S_DRN0 = 3'd3,
        S_WR1  = 3'd4,
        S_RD1  = 3'd5,
        S_DRN1 = 3'd6,
        S_DONE = 3'd7
    } state_t;

    state_t             r_state;
    state_t             w_nxt_state;
    logic [AWIDTH-1:0]  r_addr;
    logic [AWIDTH-1:0]  w_nxt_addr;
    logic               w_clear;
    logic               w_nxt_wr;
    logic               w_nxt_rd;
    logic [DWIDTH-1:0]  w_wd;
    logic               w_rd_now;
    logic               w_mismatch;

    logic               r_cmp_vld;
    logic [DWIDTH-1:0]  r_exp;
    logic [AWIDTH-1:0]  r_cmp_addr;
    logic               r_first_seen;

    // Address bits replicated across the data width, optionally inverted.
    function automatic logic [DWIDTH-1:0] f_pattern(input logic [AWIDTH-1:0] a,
                                                    input logic              inv);
        logic [DWIDTH-1:0] p;
        p = '0;
        for (int i = 0; i < DWIDTH; i++) begin
            p[i] = a[i % AWIDTH];
        end
        return inv ? ~p : p;
    endfunction

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_addr  = r_addr;
        w_clear     = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_nxt_state = S_WR0;
                    w_nxt_addr  = '0;
                    w_clear     = 1'b1;
                end
            end
            S_WR0: begin
                w_nxt_addr = r_addr + 1'b1;
                if (&r_addr) w_nxt_state = S_RD0;
            end
            S_RD0: begin
                w_nxt_addr = r_addr + 1'b1;
                if (&r_addr) w_nxt_state = S_DRN0;
            end
            S_DRN0: begin
                w_nxt_state = S_WR1;
                w_nxt_addr  = '0;
            end
            S_WR1: begin
                w_nxt_addr = r_addr + 1'b1;
                if (&r_addr) w_nxt_state = S_RD1;
            end
            S_RD1: begin
                w_nxt_addr = r_addr + 1'b1;
                if (&r_addr) w_nxt_state = S_DRN1;
            end
            S_DRN1: begin
                w_nxt_state = S_DONE;
                w_nxt_addr  = '0;
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_addr  = '0;
            end
        endcase
    end

    // RAM strobes are registered from the next-state decode so they line up
    // with the state that owns them.
    assign w_nxt_wr = (w_nxt_state == S_WR0) || (w_nxt_state == S_WR1);
    assign w_nxt_rd = (w_nxt_state == S_RD0) || (w_nxt_state == S_RD1);
    assign w_rd_now = (r_state == S_RD0) || (r_state == S_RD1);

`ifdef BRAM_BIST_ERR_INJECT_EN
    assign w_wd = f_pattern(w_nxt_addr, w_nxt_state == S_WR1)
                ^ {{(DWIDTH-1){1'b0}},
                   (w_nxt_state == S_WR0) && inj_en && (w_nxt_addr == inj_addr)};
`else
    assign w_wd = f_pattern(w_nxt_addr, w_nxt_state == S_WR1);
`endif

    assign w_mismatch = r_cmp_vld && (rq != r_exp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            rce          <= 1'b0;
            ra           <= '0;
            wce          <= 1'b0;
            wa           <= '0;
            wd           <= '0;
            r_cmp_vld    <= 1'b0;
            r_exp        <= '0;
            r_cmp_addr   <= '0;
            r_first_seen <= 1'b0;
            err_cnt      <= '0;
            fail_addr    <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_addr  <= w_nxt_addr;
            wce     <= w_nxt_wr;
            rce     <= w_nxt_rd;
            if (w_nxt_wr) begin
                wa <= w_nxt_addr;
                wd <= w_wd;
            end
            if (w_nxt_rd) begin
                ra <= w_nxt_addr;
            end
            // Expected data tracks the read issued this cycle; rq arrives next cycle.
            r_cmp_vld  <= w_rd_now;
            r_exp      <= f_pattern(r_addr, r_state == S_RD1);
            r_cmp_addr <= r_addr;
            if (w_clear) begin
                err_cnt      <= '0;
                fail_addr    <= '0;
                r_first_seen <= 1'b0;
            end else if (w_mismatch) begin
                if (~&err_cnt) err_cnt <= err_cnt + 1'b1;
                if (!r_first_seen) fail_addr <= r_cmp_addr;
                r_first_seen <= 1'b1;
            end
        end
    end

    assign busy = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done = (r_state == S_DONE);
    assign pass = done && (err_cnt == '0);

endmodule

`default_nettype wire

// File: tb/tb_bram_bist_ctrl.sv
// ============================================================================
// Module   : tb_bram_bist_ctrl
// Brief    : Directed self-checking bench for bram_bist_ctrl (AWIDTH=4, DWIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_bram_bist_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, pass;
    logic [15:0] err_cnt;
    logic [3:0]  fail_addr;
    logic        rce, wce;
    logic [3:0]  ra, wa;
    logic [7:0]  rq, wd;

    logic        start_s;
    logic        busy_s, done_s, pass_s;
    logic [1:0]  err_s;
    logic [3:0]  fail_s;
    logic        rce_s, wce_s;
    logic [3:0]  ra_s, wa_s;
    logic [7:0]  wd_s;
    logic [7:0]  rq_s;

`ifdef BRAM_BIST_ERR_INJECT_EN
    logic        inj_en;
    logic [3:0]  inj_addr;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int fault_mode = 0;
    int overlap = 0;

    logic [7:0]  mem [16];
    logic        s_wce [200];
    logic        s_rce [200];
    logic [3:0]  s_wa  [200];
    logic [3:0]  s_ra  [200];
    logic [7:0]  s_wd  [200];

    always #5 clk = ~clk;

    assign rq_s = 8'h00;

    bram_bist_ctrl #(.AWIDTH(4), .DWIDTH(8), .ECW(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .fail_addr(fail_addr),
        .rce(rce), .ra(ra), .rq(rq),
        .wce(wce), .wa(wa), .wd(wd)
`ifdef BRAM_BIST_ERR_INJECT_EN
        , .inj_en(inj_en), .inj_addr(inj_addr)
`endif
    );

    bram_bist_ctrl #(.AWIDTH(4), .DWIDTH(8), .ECW(2)) dut_sat (
        .clk(clk), .rst(rst), .start(start_s),
        .busy(busy_s), .done(done_s), .pass(pass_s),
        .err_cnt(err_s), .fail_addr(fail_s),
        .rce(rce_s), .ra(ra_s), .rq(rq_s),
        .wce(wce_s), .wa(wa_s), .wd(wd_s)
`ifdef BRAM_BIST_ERR_INJECT_EN
        , .inj_en(1'b0), .inj_addr(4'd0)
`endif
    );

    // 1-cycle-latency RAM; mode 1 = bit 3 stuck-at-0 at address 5, mode 2 = reads return 0.
    always @(posedge clk) begin
        if (wce) mem[wa] <= (fault_mode == 1 && wa == 4'd5) ? (wd & 8'hF7) : wd;
        if (rce) rq <= (fault_mode == 2) ? 8'h00 : mem[ra];
        if (rce && wce) overlap++;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Cycle 1 is the cycle after the edge that samples start; returns the
    // first cycle in which done is seen and the number of busy cycles.
    task automatic run_bist(input bit hold, output int lat, output int busy_cyc);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        lat = 1;
        busy_cyc = 0;
        while (1) begin
            if (lat < 200) begin
                s_wce[lat] = wce; s_wa[lat] = wa; s_wd[lat] = wd;
                s_rce[lat] = rce; s_ra[lat] = ra;
            end
            if (busy) busy_cyc++;
            if (done || lat >= 200) break;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bc, n;
        rst = 1'b1;
        start = 1'b0;
        start_s = 1'b0;
`ifdef BRAM_BIST_ERR_INJECT_EN
        inj_en = 1'b0;
        inj_addr = 4'd0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_flags", {busy, done, pass, rce, wce}, 5'b0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_fail_addr", fail_addr, 0);
        chk("rst_addr_data", {ra, wa, wd}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Fault-free run
        fault_mode = 0;
        run_bist(0, lat, bc);
        chk("clean_done_cycle", lat, 67);
        chk("clean_busy_cycles", bc, 66);
        chk("clean_pass", pass, 1);
        chk("clean_err_cnt", err_cnt, 0);
        chk("clean_fail_addr", fail_addr, 0);
        chk("wr0_first", {s_wce[1], s_wa[1], s_wd[1]}, {1'b1, 4'd0, 8'h00});
        chk("wr0_addr5", {s_wce[6], s_wa[6], s_wd[6]}, {1'b1, 4'd5, 8'h55});
        chk("rd0_addr1", {s_rce[18], s_wce[18], s_ra[18]}, {1'b1, 1'b0, 4'd1});
        chk("drn0_idle", {s_rce[33], s_wce[33]}, 2'b00);
        chk("wr1_first", {s_wce[34], s_wa[34], s_wd[34]}, {1'b1, 4'd0, 8'hFF});
        chk("wr1_addr5", {s_wce[39], s_wa[39], s_wd[39]}, {1'b1, 4'd5, 8'hAA});
        chk("rd1_last", {s_rce[65], s_ra[65]}, {1'b1, 4'd15});
        chk("drn1_idle", {s_rce[66], s_wce[66]}, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        chk("done_hold", {busy, done, pass}, 3'b011);

        // Bit 3 stuck-at-0 at address 5
        fault_mode = 1;
        run_bist(0, lat, bc);
        chk("stuck_done_cycle", lat, 67);
        chk("stuck_err_cnt", err_cnt, 1);
        chk("stuck_fail_addr", fail_addr, 5);
        chk("stuck_pass", pass, 0);

        // start held high: no restart while busy, restart from DONE clears err_cnt
        run_bist(1, lat, bc);
        chk("hold_done_cycle", lat, 67);
        chk("hold_err_before", err_cnt, 1);
        @(posedge clk);
        #1;
        chk("hold_restart", {busy, done}, 2'b10);
        chk("hold_err_cleared", err_cnt, 0);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("hold_second_done", done, 1);
        chk("hold_second_err", err_cnt, 1);

        // Asynchronous reset inside RD0
        fault_mode = 2;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        chk("pre_rst_rd0", {busy, rce, wce}, 3'b110);
        chk("pre_rst_err", err_cnt, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_flags", {busy, rce, wce}, 3'b000);
        chk("async_rst_err", err_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        fault_mode = 0;
        run_bist(0, lat, bc);
        chk("post_rst_done_cycle", lat, 67);
        chk("post_rst_pass", pass, 1);

`ifdef BRAM_BIST_ERR_INJECT_EN
        inj_en = 1'b1;
        inj_addr = 4'd9;
        run_bist(0, lat, bc);
        chk("inj_err_cnt", err_cnt, 1);
        chk("inj_fail_addr", fail_addr, 9);
        chk("inj_pass", pass, 0);
        inj_en = 1'b0;
        run_bist(0, lat, bc);
        chk("inj_off_pass", pass, 1);
`endif

        // Saturating counter with an all-zero RAM
        @(negedge clk);
        start_s = 1'b1;
        @(posedge clk);
        #1;
        start_s = 1'b0;
        n = 1;
        while (!done_s && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("sat_done_cycle", n, 67);
        chk("sat_err_cnt", err_s, 3);
        chk("sat_fail_addr", fail_s, 1);
        chk("sat_pass", pass_s, 0);

        chk("no_rce_wce_overlap", overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
